// File: rtl/tvip_apb_reg_slave.sv
// APB register-bank completer with configurable width, depth and wait states.
// Errors on misaligned or out-of-range addresses; saturating error counter.
module tvip_apb_reg_slave #(
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    NUM_REGS    = 8,
  parameter int                    WAIT_STATES = 0,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic                           apb_sel,
  input  logic                           apb_enable,
  input  logic [ADDR_WIDTH-1:0]          apb_addr,
  input  logic                           apb_write,
  input  logic [DATA_WIDTH-1:0]          apb_wdata,
  output logic                           apb_ready,
  output logic [DATA_WIDTH-1:0]          apb_rdata,
  output logic                           apb_slverr,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr_pulse,
  output logic [7:0]                     err_count
);

  localparam int ADDR_LSB = $clog2(DATA_WIDTH / 8);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
  localparam logic [ADDR_WIDTH-1:0] LSB_MASK =
    ADDR_WIDTH'((1 << ADDR_LSB) - 1);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   pulse_q, pulse_d;
  logic [7:0]            errc_q, errc_d;

  logic [IDX_W-1:0] idx;
  logic [31:0]      idx_ext;
  logic             misaligned;
  logic             out_of_range;
  logic             addr_err;
  logic             done;

  // Address decode into register index and error flag
  always_comb begin
    idx          = apb_addr[ADDR_WIDTH-1:ADDR_LSB];
    idx_ext      = 32'(idx);
    misaligned   = |(apb_addr & LSB_MASK);
    out_of_range = idx_ext >= 32'(NUM_REGS);
    addr_err     = misaligned | out_of_range;
  end

  // State and wait-counter registers
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: enter access on select, count down, leave on completion
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (apb_sel) begin
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_STATES);
        end
      end
      ACCESS: begin
        if (!apb_sel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (apb_enable) begin
          if (cnt_q != '0) cnt_d = cnt_q - 4'd1;
          else state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus response: ready, error and read data only in completion
  always_comb begin
    apb_ready  = (state_q == ACCESS) && (cnt_q == '0) && apb_enable;
    done       = apb_ready && apb_sel;
    apb_slverr = done && addr_err;
    apb_rdata  = '0;
    if (done && !apb_write && !addr_err) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (idx_ext == 32'(i)) apb_rdata = regs_q[i];
      end
    end
  end

  // Register update, write pulse and saturating error count
  always_comb begin
    regs_d  = regs_q;
    pulse_d = '0;
    errc_d  = errc_q;
    if (done && apb_write && !addr_err) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (idx_ext == 32'(i)) begin
          regs_d[i]  = apb_wdata;
          pulse_d[i] = 1'b1;
        end
      end
    end
    if (apb_slverr && errc_q != 8'hFF) errc_d = errc_q + 8'd1;
  end

  // Register bank, pulse and counter flops
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VALUE;
      pulse_q <= '0;
      errc_q  <= '0;
    end else begin
      regs_q  <= regs_d;
      pulse_q <= pulse_d;
      errc_q  <= errc_d;
    end
  end

  // Flatten the bank onto the export bus
  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end
  end

  assign reg_wr_pulse = pulse_q;
  assign err_count    = errc_q;

endmodule
